// File: rtl/led_breather_pkg.sv
// led_breather_pkg: shared types and helpers for the LED breather.
//   state_e : ramp FSM state encoding (exported on the STATE port)
//   gamma() : squared-level perceptual correction, used only when the
//             LED_BREATHER_GAMMA_EN macro is defined
package led_breather_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_e;

    // Hold counter width; covers HOLD_TICKS up to 255.
    localparam int unsigned HOLD_W = 8;

    // (level*level) >> width from a full-width product; supports width <= 16.
    function automatic logic [15:0] gamma(input logic [15:0] level,
                                          input int unsigned width);
        logic [31:0] sq;
        sq = level * level;
        return 16'(sq >> width);
    endfunction

endpackage

// File: rtl/led_breather_pwm_gen.sv
// pwm_gen: free-running PWM generator with a period-aligned duty shadow.
//   clk, rst_n : clock, asynchronous active-low reset
//   compare    : requested duty, sampled only when the counter is at MAX
//   clear      : forces the shadow duty to 0 at once (bypasses the shadow)
//   o          : registered PWM output, o = (pwm_cnt < duty_active)
module pwm_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] compare,
    input  logic             clear,
    output logic             o
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] pwm_cnt;
    logic [WIDTH-1:0] duty_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt     <= '0;
            duty_active <= '0;
            o           <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            // Loading on the MAX cycle makes the new duty start cleanly
            // with the period beginning at pwm_cnt == 0.
            if (clear)
                duty_active <= '0;
            else if (pwm_cnt == MAX)
                duty_active <= compare;
            o <= (pwm_cnt < duty_active);
        end
    end

endmodule

// File: rtl/led_breather.sv
// led_breather: breathing-LED PWM driven by a slow tick time base.
//   CLK, RESETB : clock, asynchronous active-low reset
//   TICK        : one-cycle time-base pulse; each high cycle is one tick
//   EN          : level enable; low forces IDLE and clears the PWM duty
//   O           : registered PWM output to the LED pad
//   LEVEL       : current ramp duty (before gamma / shadowing)
//   STATE       : current FSM state (led_breather_pkg::state_e)
// Build option: define LED_BREATHER_GAMMA_EN to load (LEVEL^2 >> WIDTH)
// into the PWM instead of LEVEL.
module led_breather
    import led_breather_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HOLD_TICKS = 4
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             TICK,
    input  logic             EN,
    output logic             O,
    output logic [WIDTH-1:0] LEVEL,
    output logic [2:0]       STATE
);

    localparam logic [WIDTH-1:0]  MAX       = '1;
    localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    state_e             state, state_next;
    logic [WIDTH-1:0]   level, level_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_next;
    logic [WIDTH-1:0]   compare;

    // State register (with LEVEL and hold counter)
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state    <= IDLE;
            level    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            level    <= level_next;
            hold_cnt <= hold_next;
        end
    end

    // Next-state logic; the boundary tests on the pre-update value keep
    // LEVEL from ever stepping past MAX or below 0.
    always_comb begin
        state_next = state;
        level_next = level;
        hold_next  = hold_cnt;
        if (!EN) begin
            state_next = IDLE;
            level_next = '0;
            hold_next  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = RISE;
                    level_next = '0;
                    hold_next  = '0;
                end
                RISE: if (TICK) begin
                    level_next = level + 1'b1;
                    if (level == MAX - ONE) begin
                        state_next = HOLD_HI;
                        hold_next  = '0;
                    end
                end
                HOLD_HI: if (TICK) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = FALL;
                        hold_next  = '0;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
                FALL: if (TICK) begin
                    level_next = level - 1'b1;
                    if (level == ONE) begin
                        state_next = HOLD_LO;
                        hold_next  = '0;
                    end
                end
                HOLD_LO: if (TICK) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_next = RISE;
                        hold_next  = '0;
                    end else begin
                        hold_next = hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    level_next = '0;
                    hold_next  = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        STATE = state;
        LEVEL = level;
    end

`ifdef LED_BREATHER_GAMMA_EN
    always_comb compare = WIDTH'(gamma(16'(level), WIDTH));
`else
    always_comb compare = level;
`endif

    pwm_gen #(.WIDTH(WIDTH)) u_pwm (
        .clk     (CLK),
        .rst_n   (RESETB),
        .compare (compare),
        .clear   (~EN),
        .o       (O)
    );

endmodule

// File: tb/tb_led_breather.sv
module tb_led_breather;

  localparam int W  = 4;
  localparam int HT = 2;

  localparam int S_IDLE = 0, S_RISE = 1, S_HOLD_HI = 2, S_FALL = 3, S_HOLD_LO = 4;

  logic         clk = 1'b0;
  logic         rstb;
  logic         tick;
  logic         en;
  logic         o;
  logic [W-1:0] level;
  logic [2:0]   state;

  int           checks   = 0;
  int           failures = 0;
  int           o_high   = 0;
  logic [W-1:0] mcnt;

  led_breather #(.WIDTH(W), .HOLD_TICKS(HT)) dut (
    .CLK    (clk),
    .RESETB (rstb),
    .TICK   (tick),
    .EN     (en),
    .O      (o),
    .LEVEL  (level),
    .STATE  (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstb)
    if (!rstb) mcnt <= '0;
    else       mcnt <= mcnt + 1'b1;

  function automatic int exp_duty(input int l);
`ifdef LED_BREATHER_GAMMA_EN
    return (l * l) >> W;
`else
    return l;
`endif
  endfunction

  task automatic fail(input string name, input int act, input int exp);
    failures++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick_n(input int n);
    for (int unsigned i = 0; i < n; i++) begin
      repeat (19) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic sync_period;
    while (mcnt != '0) @(negedge clk);
  endtask

  task automatic window(input int tick_at);
    o_high = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      @(negedge clk);
      o_high += int'(o);
      if (int'(i) == tick_at)     tick = 1'b1;
      if (int'(i) == tick_at + 1) tick = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0;
    en   = 1'b0;
    tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o !== 1'b0) fail("reset_o", int'(o), 0);
    checks++; if (int'(level) !== 0) fail("reset_level", int'(level), 0);
    checks++; if (int'(state) !== S_IDLE) fail("reset_state", int'(state), S_IDLE);
    rstb = 1'b1;
    @(negedge clk);

    en = 1'b1;
    @(negedge clk);
    checks++; if (int'(state) !== S_RISE) fail("en_state_rise", int'(state), S_RISE);
    checks++; if (int'(level) !== 0) fail("en_level_zero", int'(level), 0);
    o_high = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      @(negedge clk);
      o_high += int'(o);
    end
    checks++; if (o_high !== 0) fail("level0_o_high64", o_high, 0);
    @(negedge clk);

    tick_n(15);
    checks++; if (int'(level) !== 15) fail("rise_level15", int'(level), 15);
    checks++; if (int'(state) !== S_HOLD_HI) fail("rise_to_hold_hi", int'(state), S_HOLD_HI);
    tick_n(1);
    checks++; if (int'(state) !== S_HOLD_HI) fail("hold_hi_mid", int'(state), S_HOLD_HI);
    tick_n(1);
    checks++; if (int'(state) !== S_FALL) fail("hold_hi_to_fall", int'(state), S_FALL);
    checks++; if (int'(level) !== 15) fail("fall_start_level", int'(level), 15);
    tick_n(15);
    checks++; if (int'(state) !== S_HOLD_LO) fail("fall_to_hold_lo", int'(state), S_HOLD_LO);
    checks++; if (int'(level) !== 0) fail("fall_level0", int'(level), 0);
    tick_n(2);
    checks++; if (int'(state) !== S_RISE) fail("hold_lo_to_rise", int'(state), S_RISE);

    tick_n(5);
    checks++; if (int'(level) !== 5) fail("level5", int'(level), 5);
    repeat (20) @(negedge clk);
    sync_period();
    window(-10);
    checks++; if (o_high !== exp_duty(5)) fail("duty5_window", o_high, exp_duty(5));
    window(4);
    checks++; if (o_high !== exp_duty(5)) fail("shadow_period_old_duty", o_high, exp_duty(5));
    checks++; if (int'(level) !== 6) fail("level6", int'(level), 6);
    window(-10);
    checks++; if (o_high !== exp_duty(6)) fail("duty6_window", o_high, exp_duty(6));

    tick_n(9);
    tick_n(2);
    tick_n(6);
    checks++; if (int'(level) !== 9) fail("fall_level9", int'(level), 9);
    checks++; if (int'(state) !== S_FALL) fail("fall_state", int'(state), S_FALL);
    en   = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    checks++; if (int'(state) !== S_IDLE) fail("en_off_state", int'(state), S_IDLE);
    checks++; if (int'(level) !== 0) fail("en_off_level", int'(level), 0);
    @(negedge clk);
    o_high = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      o_high += int'(o);
      tick = (i % 3 == 0);
      @(negedge clk);
    end
    tick = 1'b0;
    checks++; if (o_high !== 0) fail("en_off_o_zero", o_high, 0);
    checks++; if (int'(state) !== S_IDLE) fail("en_off_tick_ignored_state", int'(state), S_IDLE);
    checks++; if (int'(level) !== 0) fail("en_off_tick_ignored_level", int'(level), 0);

    en = 1'b1;
    @(negedge clk);
    checks++; if (int'(state) !== S_RISE) fail("reenable_rise", int'(state), S_RISE);
    tick_n(16);
    checks++; if (int'(state) !== S_HOLD_HI) fail("hold_hi_again", int'(state), S_HOLD_HI);
    sync_period();
    window(-10);
    checks++; if (o_high !== exp_duty(15)) fail("duty15_window", o_high, exp_duty(15));
    #2 rstb = 1'b0;
    #1;
    checks++; if (o !== 1'b0) fail("async_rst_o", int'(o), 0);
    checks++; if (int'(level) !== 0) fail("async_rst_level", int'(level), 0);
    checks++; if (int'(state) !== S_IDLE) fail("async_rst_state", int'(state), S_IDLE);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    checks++; if (int'(state) !== S_RISE) fail("post_rst_rise", int'(state), S_RISE);
    checks++; if (int'(level) !== 0) fail("post_rst_level", int'(level), 0);

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
